// File: rtl/in_dev_feeder.sv
// Byte feeder: a small circular FIFO drained by a four-phase req/ack handshake
// toward a processor input port, with a per-edge ack timeout and sticky error.
module in_dev_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     g_clk,
    input  logic                     g_clr,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     in_dev_ack,
    input  logic                     err_clr,
    output logic                     in_dev_hs,
    output logic [7:0]               input_bus,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, REQ, REL, ERR} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [WW-1:0]   wait_cnt;
    logic            push, pop, wait_done;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state != IDLE);
    assign push      = wr_en && !full;
    assign pop       = (state == REL) && !in_dev_ack;
    // Fires on the cycle whose edge would take the counter to TIMEOUT.
    assign wait_done = (wait_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge g_clk) begin
        if (push && !g_clr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            state       <= IDLE;
            in_dev_hs   <= 1'b0;
            input_bus   <= 8'h00;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            // A timeout raised on the same edge takes precedence over the clear.
            if (err_clr) timeout_err <= 1'b0;
            case (state)
                IDLE: if (!empty) begin
                    input_bus <= mem[rd_ptr];
                    state     <= SETUP;
                end
                SETUP: begin
                    state     <= REQ;
                    in_dev_hs <= 1'b1;
                    wait_cnt  <= '0;
                end
                REQ: begin
                    if (in_dev_ack) begin
                        state     <= REL;
                        in_dev_hs <= 1'b0;
                        wait_cnt  <= '0;
                    end else if (wait_done) begin
                        state       <= ERR;
                        in_dev_hs   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                REL: begin
                    if (!in_dev_ack) begin
                        state <= IDLE;
                    end else if (wait_done) begin
                        state       <= ERR;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ERR: if (!in_dev_ack && err_clr) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_in_dev_feeder.sv
// Bench for in_dev_feeder: queue-based transaction model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_in_dev_feeder;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic       g_clk = 1'b0, g_clr = 1'b1, wr_en = 1'b0, in_dev_ack = 1'b0, err_clr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       in_dev_hs, full, empty, busy, timeout_err;
    logic [7:0] input_bus;
    logic [2:0] count;

    in_dev_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .g_clk(g_clk), .g_clr(g_clr), .wr_en(wr_en), .wr_data(wr_data),
        .in_dev_ack(in_dev_ack), .err_clr(err_clr), .in_dev_hs(in_dev_hs),
        .input_bus(input_bus), .full(full), .empty(empty), .count(count),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 g_clk = ~g_clk;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: queue of pending bytes plus the handshake phase of the head byte
    // (0 idle, 1 data setup, 2 waiting for ack, 3 waiting for release, 4 error hold).
    logic [7:0] q[$];
    int         ph = 0, w = 0;
    bit         m_hs = 0, m_terr = 0, m_pop, m_full, m_set;
    logic [7:0] m_bus = 8'h00;

    always @(posedge g_clk) begin
        if (g_clr) begin
            q.delete(); ph = 0; w = 0; m_hs = 0; m_bus = 8'h00; m_terr = 0;
        end else begin
            m_pop  = (ph == 3) && !in_dev_ack;
            m_full = (q.size() == DEPTH);
            m_set  = 0;
            case (ph)
                0: if (q.size() > 0) begin m_bus = q[0]; ph = 1; end
                1: begin ph = 2; m_hs = 1; w = 0; end
                2: if (in_dev_ack) begin ph = 3; m_hs = 0; w = 0; end
                   else if (w + 1 == TIMEOUT) begin ph = 4; m_hs = 0; m_set = 1; end
                   else w++;
                3: if (!in_dev_ack) ph = 0;
                   else if (w + 1 == TIMEOUT) begin ph = 4; m_set = 1; end
                   else w++;
                default: if (!in_dev_ack && err_clr) ph = 0;
            endcase
            if (m_set) m_terr = 1;
            else if (err_clr) m_terr = 0;
            if (m_pop) void'(q.pop_front());
            if (wr_en && !m_full) q.push_back(wr_data);
        end
    end

    always @(negedge g_clk) begin
        if (chk_en) begin
            chk("hs",    in_dev_hs,   m_hs);
            chk("bus",   input_bus,   m_bus);
            chk("count", count,       q.size());
            chk("full",  full,        q.size() == DEPTH);
            chk("empty", empty,       q.size() == 0);
            chk("busy",  busy,        ph != 0);
            chk("terr",  timeout_err, m_terr);
        end
    end

    // Bytes presented at each hs rising edge.
    logic [7:0] got[$];
    bit         hs_mon = 0;
    always @(negedge g_clk) begin
        if (in_dev_hs && !hs_mon) got.push_back(input_bus);
        hs_mon = in_dev_hs;
    end

    // ack_mode: 0 held low, 1 follows hs one cycle late, 2 random.
    int ack_mode = 0;
    bit hs_d = 0;
    task automatic tick();
        @(negedge g_clk);
        #1;
        case (ack_mode)
            1:       in_dev_ack = hs_d;
            2:       in_dev_ack = 1'($urandom_range(0, 1));
            default: in_dev_ack = 1'b0;
        endcase
        hs_d = in_dev_hs;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
    endtask

    task automatic wait_hs();
        int n = 0;
        while (!in_dev_hs && n < 30) begin tick(); n++; end
        chk("hs_rise_seen", in_dev_hs, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !empty) && n < 300) begin tick(); n++; end
        chk("drain_done", busy || !empty, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;
        logic [7:0] prev_bus;
        logic [2:0] pre;

        // Reset, with pushes presented during reset
        g_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        tick(); tick();
        chk_en = 1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_hs",    in_dev_hs, 0);
        chk("rst_bus",   input_bus, 8'h00);
        chk("rst_terr",  timeout_err, 0);
        g_clr = 1'b0; wr_en = 1'b0;
        tick();

        // Single byte, ack one cycle behind hs
        ack_mode = 1; got.delete();
        push(8'h0A);
        n = 0; prev_bus = input_bus;
        while (!in_dev_hs && n < 30) begin prev_bus = input_bus; tick(); n++; end
        chk("single_hs_rise", in_dev_hs, 1);
        chk("single_bus_before_hs", prev_bus, 8'h0A);
        n = 0;
        while (in_dev_hs && n < 30) begin n++; tick(); end
        chk("single_hs_cycles", n, 2);
        wait_idle();
        chk("single_empty", empty, 1);
        chk("single_byte", got.size() == 1 && got[0] == 8'h0A, 1);

        // Fill past full with ack held low, then release and check order
        ack_mode = 0; got.delete();
        for (int i = 1; i <= 5; i++) push(8'(8'h11 * i));
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        ack_mode = 1;
        wait_idle();
        chk("fill_n", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("fill_order", got[i], 8'(8'h11 * (i + 1)));

        // Push on the pop edge at count 2; write pointer wraps 3 -> 0
        got.delete();
        push(8'hC1); push(8'hC2); push(8'hC3);
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (ph == 3 && !in_dev_ack && q.size() == 2) begin
                pre = count;
                push(8'hC4);
                chk("pp_count_before", pre, 2);
                chk("pp_count_after", count, 2);
                found = 1;
            end else begin
                tick();
            end
        end
        chk("pp_found", found, 1);
        wait_idle();
        chk("pp_n", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("pp_order", got[i], 8'(8'hC1 + i));

        // Timeout and resend
        ack_mode = 0; got.delete();
        push(8'hA5);
        wait_hs();
        n = 0;
        while (in_dev_hs && n < 30) begin n++; tick(); end
        chk("to_hs_cycles", n, TIMEOUT);
        chk("to_terr", timeout_err, 1);
        chk("to_count", count, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("to_terr_cleared", timeout_err, 0);
        ack_mode = 1;
        wait_idle();
        chk("to_resend", got.size() == 2 && got[1] == 8'hA5, 1);

        // Reset in the middle of a request
        ack_mode = 0;
        push(8'hB1); push(8'hB2);
        wait_hs();
        g_clr = 1'b1; tick(); g_clr = 1'b0;
        chk("mid_rst_hs", in_dev_hs, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_bus", input_bus, 8'h00);
        chk("mid_rst_busy", busy, 0);
        tick();

        // Randomized traffic
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_data = 8'($urandom);
            err_clr = ($urandom_range(0, 7) == 0);
            g_clr   = ($urandom_range(0, 399) == 0);
            tick();
        end
        wr_en = 1'b0; err_clr = 1'b0; g_clr = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
